// File: rtl/data_mem_responder.sv
// Byte-lane data memory for the MEM stage: combinational big-endian reads, edge-committed partial writes.
// Define DM_WAIT_STATES_EN to add the IDLE/WAIT/RESP wait-state handshake; otherwise every access completes at once.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] data_address_2DM,
    input  logic [31:0] data_write_2DM,
    input  logic [1:0]  data_write_size_2DM,
    input  logic        MemRead_2DM,
    input  logic        MemWrite_2DM,
    output logic [31:0] data_read_fDM,
    output logic        data_ready_fDM,
    output logic [1:0]  o_dbg_state
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [2:0]    w_nbytes;
    logic [31:0]   w_merged;
    logic          w_we;
    logic          w_unused_addr;

    // Address bits above the array depth alias back onto it.
    assign w_idx         = data_address_2DM[AW+1:2];
    assign w_off         = data_address_2DM[1:0];
    assign w_unused_addr = ^data_address_2DM[31:AW+2];
    assign w_nbytes      = (data_write_size_2DM == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DM};

    assign data_read_fDM = r_mem[w_idx];

    // Lane j takes store byte (n-1-(j-k)) when it falls inside the k..k+n-1 window; lanes past 3 are dropped.
    always_comb begin
        w_merged = data_read_fDM;
        for (int j = 0; j < 4; j++) begin
            if ((j >= int'(w_off)) && ((j - int'(w_off)) < int'(w_nbytes))) begin
                w_merged[8*(3-j) +: 8] = data_write_2DM[8*(int'(w_nbytes) - 1 - (j - int'(w_off))) +: 8];
            end
        end
    end

    // The array has no reset so its contents survive RESET.
    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

`ifdef DM_WAIT_STATES_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_ready;
    logic          w_req;

    assign w_req = MemRead_2DM | MemWrite_2DM;

    // The write lands on the edge that leaves RESP, so a reset in flight simply never reaches it.
    assign w_we           = (r_state == S_RESP) & MemWrite_2DM;
    assign data_ready_fDM = r_ready;
    assign o_dbg_state    = r_state;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (w_req) begin
                        r_cnt   <= CW'(WAIT_CYCLES);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
`else
    logic w_unused_cfg;

    // Without wait states the memory is always ready outside reset and MemRead_2DM carries no information.
    assign w_unused_cfg   = MemRead_2DM ^ (WAIT_CYCLES < 0);
    assign w_we           = MemWrite_2DM & ~RESET;
    assign data_ready_fDM = ~RESET;
    assign o_dbg_state    = 2'd0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, randomized traffic against a word/byte-lane model, reset corners.
// Covers the default build and, when DM_WAIT_STATES_EN is defined, the wait-state handshake.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        rd;
    logic        we;
    logic [31:0] rdata;
    logic        ready;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        rd;
        logic        we;
        logic [31:0] rd_addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .CLK                 (clk),
        .RESET               (rst),
        .data_address_2DM    (addr),
        .data_write_2DM      (wdata),
        .data_write_size_2DM (size),
        .MemRead_2DM         (rd),
        .MemWrite_2DM        (we),
        .data_read_fDM       (rdata),
        .data_ready_fDM      (ready),
        .o_dbg_state         (dbg_state)
    );

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH));
    endfunction

    // Byte lanes are numbered from the most significant byte; the store source is right-justified.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                          input logic [31:0] d, input logic [1:0] sz);
        logic [7:0] lane [4];
        int n;
        int k;
        n = (sz == 2'd0) ? 4 : int'(sz);
        k = int'(a[1:0]);
        for (int j = 0; j < 4; j++) lane[j] = old[31-8*j -: 8];
        for (int i = 0; i < n; i++) begin
            if (k + i < 4) lane[k+i] = d[8*(n-1-i) +: 8];
        end
        return {lane[0], lane[1], lane[2], lane[3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input logic r, input logic w);
        addr  = a;
        wdata = d;
        size  = sz;
        rd    = r;
        we    = w;
    endtask

    task automatic check_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        drive(a, 32'h0, 2'd0, 1'b0, 1'b0);
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input logic r, input logic w);
        logic [31:0] pre;
        pre = model[widx(a)];
`ifndef DM_WAIT_STATES_EN
        @(negedge clk);
        drive(a, d, sz, r, w);
        #1;
        chk("nowait_ready", {31'b0, ready}, 32'd1);
        chk("pre_write_read", rdata, pre);
        @(posedge clk);
        if (w) model[widx(a)] = merge(pre, a, d, sz);
`else
        if (!(r || w)) begin
            @(negedge clk);
            drive(a, d, sz, r, w);
            @(posedge clk);
            #1;
            chk("idle_no_ready", {31'b0, ready}, 32'd0);
        end else begin
            int  edges;
            bit  got;
            edges = 0;
            got   = 1'b0;
            @(negedge clk);
            drive(a, d, sz, r, w);
            while (!got && edges < 20) begin
                @(posedge clk);
                edges++;
                #1;
                if (ready) got = 1'b1;
                else chk("wait_read_old", rdata, pre);
            end
            chk("ready_seen", {31'b0, got}, 32'd1);
            chk("ready_latency", 32'(edges), 32'(WAITC + 2));
            chk("resp_read_old", rdata, pre);
            @(posedge clk);
            #1;
            chk("ready_one_cycle", {31'b0, ready}, 32'd0);
            if (w) model[widx(a)] = merge(pre, a, d, sz);
            chk("post_commit_read", rdata, model[widx(a)]);
            @(negedge clk);
            drive(a, d, sz, 1'b0, 1'b0);
        end
`endif
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] pre;
        logic [1:0]  sz;
        logic        r;
        logic        w;

        vecs[0]  = '{32'h40,       32'hDEADBEEF, 2'd0, 1'b0, 1'b1, 32'h40,       32'hDEADBEEF};
        vecs[1]  = '{32'h44,       32'h11223344, 2'd0, 1'b0, 1'b1, 32'h44,       32'h11223344};
        vecs[2]  = '{32'h45,       32'h000000AA, 2'd1, 1'b0, 1'b1, 32'h44,       32'h11AA3344};
        vecs[3]  = '{32'h44,       32'h11223344, 2'd0, 1'b0, 1'b1, 32'h44,       32'h11223344};
        vecs[4]  = '{32'h45,       32'h00C0FFEE, 2'd3, 1'b0, 1'b1, 32'h44,       32'h11C0FFEE};
        vecs[5]  = '{32'h47,       32'h0000BEEF, 2'd2, 1'b0, 1'b1, 32'h44,       32'h11C0FFBE};
        vecs[6]  = '{32'h1000,     32'h0BADF00D, 2'd0, 1'b0, 1'b1, 32'h0,        32'h0BADF00D};
        vecs[7]  = '{32'h48,       32'hAABBCCDD, 2'd0, 1'b0, 1'b1, 32'h48,       32'hAABBCCDD};
        vecs[8]  = '{32'h4A,       32'hFFFF1234, 2'd2, 1'b0, 1'b1, 32'h48,       32'hAABB1234};
        vecs[9]  = '{32'h4B,       32'h77777755, 2'd1, 1'b0, 1'b1, 32'h48,       32'hAABB1255};
        vecs[10] = '{32'h48,       32'h00010203, 2'd3, 1'b0, 1'b1, 32'h48,       32'h01020355};
        vecs[11] = '{32'hFFFFF04C, 32'h5A5AA5A5, 2'd0, 1'b0, 1'b1, 32'h4C,       32'h5A5AA5A5};
        vecs[12] = '{32'h40,       32'h00000000, 2'd0, 1'b1, 1'b0, 32'h40,       32'hDEADBEEF};
        vecs[13] = '{32'h4C,       32'h00000000, 2'd0, 1'b1, 1'b0, 32'hFFFFF04C, 32'h5A5AA5A5};

        drive(32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        chk("reset_ready", {31'b0, ready}, 32'd0);
        chk("reset_state", {30'b0, dbg_state}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
`ifdef DM_WAIT_STATES_EN
        chk("idle_ready_after_reset", {31'b0, ready}, 32'd0);
`else
        chk("ready_after_reset", {31'b0, ready}, 32'd1);
`endif

        for (int i = 0; i < DEPTH; i++) begin
            do_op(32'(i * 4), $urandom, 2'd0, 1'b0, 1'b1);
        end
        check_read(32'h0, model[0], "fill_first");
        check_read(32'(4 * (DEPTH - 1)), model[DEPTH-1], "fill_last");

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].rd, vecs[i].we);
            check_read(vecs[i].rd_addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 200; i++) begin
            a  = $urandom;
            d  = $urandom;
            sz = 2'($urandom_range(0, 3));
            r  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            do_op(a, d, sz, r, w);
            check_read(a, model[widx(a)], "rand_same");
            a = $urandom;
            check_read(a, model[widx(a)], "rand_other");
        end

`ifndef DM_WAIT_STATES_EN
        pre = model[widx(32'h90)];
        @(negedge clk);
        rst = 1'b1;
        drive(32'h90, 32'hCAFEDEAD, 2'd0, 1'b0, 1'b1);
        #1;
        chk("reset_pulse_ready", {31'b0, ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_pulse_ready_edge", {31'b0, ready}, 32'd0);
        @(negedge clk);
        drive(32'h90, 32'h0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("reset_discards_write", rdata, pre);
        chk("ready_after_pulse", {31'b0, ready}, 32'd1);
`else
        pre = model[widx(32'h90)];
        @(negedge clk);
        drive(32'h90, 32'hCAFEDEAD, 2'd0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_wait_ready", {31'b0, ready}, 32'd0);
        chk("reset_wait_state", {30'b0, dbg_state}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(32'h90, 32'h0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("reset_wait_no_ready", {31'b0, ready}, 32'd0);
        end
        chk("reset_wait_word", rdata, pre);

        pre = model[widx(32'h94)];
        @(negedge clk);
        drive(32'h94, 32'h13572468, 2'd0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        drive(32'h94, 32'h13572468, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_ready", {31'b0, ready}, 32'd0);
        end
        chk("abort_state_idle", {30'b0, dbg_state}, 32'd0);
        chk("abort_word", rdata, pre);
        do_op(32'h94, 32'h2468ACE0, 2'd0, 1'b0, 1'b1);
        check_read(32'h94, 32'h2468ACE0, "after_abort_write");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, memory depth in 32-bit words; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states per access; used only with DM_WAIT_STATES_EN.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 data_address_2DM  input  32  byte address from the MEM stage.
REQ-006 data_write_2DM  input  32  store data, right-justified (low bytes significant).
REQ-007 data_write_size_2DM  input  2  store byte count: 0=4, 1=1, 2=2, 3=3.
REQ-008 MemRead_2DM  input  1  read request.
REQ-009 MemWrite_2DM  input  1  write request.
REQ-010 data_read_fDM  output  32  word at the word-aligned address, big-endian lanes (byte 0 = [31:24]).
REQ-011 data_ready_fDM  output  1  access complete / write committed this cycle.

Function
REQ-012 Word index SHALL be data_address_2DM[31:2] modulo DEPTH_WORDS; high bits ignored (wrap).
REQ-013 data_read_fDM SHALL be combinational from the array at the current index; no latency.
REQ-014 Write of n bytes (n from REQ-007) at offset k=addr[1:0]: byte lane k+i receives data_write_2DM byte (n-1-i), i=0..n-1; lanes >3 dropped; other lanes unchanged.
REQ-015 Writes SHALL commit only at a rising edge; same-cycle read returns pre-write contents.
REQ-016 MemRead_2DM and MemWrite_2DM both high: treated as a write; data_read_fDM still shows pre-write word.
REQ-017 Neither request high: no array change; data_ready_fDM low (wait mode) or high (no-wait mode).
REQ-018 Wait-mode FSM states IDLE, WAIT, RESP; IDLE->WAIT at edge E0 where a request is present, counter loaded with WAIT_CYCLES.
REQ-019 WAIT: counter decrements each edge; at edge where counter is 0 go to RESP (WAIT_CYCLES=0 -> RESP one edge after E0).
REQ-020 RESP: data_ready_fDM high for exactly one cycle; write committed at the edge leaving RESP; next state IDLE.
REQ-021 Requester SHALL hold address/data/size/request stable from E0 through RESP; changes meanwhile are undefined.
REQ-022 Request still high in IDLE after RESP SHALL be a new access (no merging).
REQ-023 Request dropped during WAIT SHALL abort: back to IDLE next edge, no write, no ready pulse.

Reset
REQ-024 RESET high SHALL immediately force state IDLE, counter 0, data_ready_fDM 0.
REQ-025 Array contents SHALL NOT be cleared by reset; an in-flight write is discarded.
REQ-026 After RESET falls, first accepting edge SHALL be the next rising edge.

Configuration
REQ-027 Macro DM_WAIT_STATES_EN defined: FSM of REQ-018..023 active, WAIT_CYCLES honoured.
REQ-028 Macro undefined: no FSM; writes commit every edge with MemWrite_2DM high; data_ready_fDM = 1 whenever RESET low.

Verification
REQ-029 No-wait: SW addr 0x40 data 0xDEADBEEF size 0, then read 0x40 -> data_read_fDM 0xDEADBEEF.
REQ-030 Word 0x44 = 0x11223344; SB addr 0x45 data 0x000000AA size 1 -> word 0x11AA3344.
REQ-031 Word 0x44 = 0x11223344; write addr 0x45 data 0x00C0FFEE size 3 -> 0x11C0FFEE; then addr 0x47 data 0x0000BEEF size 2 -> 0x11C0FFBE.
REQ-032 Wait mode WAIT_CYCLES=2: write 0x12345678 to 0x80 at E0 -> ready high only in cycle after E0+3 edges; read 0x80 before commit -> old value, after -> 0x12345678.
REQ-033 Wait mode: RESET pulsed during WAIT of write 0xCAFEDEAD to 0x90 -> ready 0, state IDLE, word 0x90 unchanged.
REQ-034 Address 0x1000 with DEPTH_WORDS=1024 -> aliases word 0 (write 0x0BADF00D, read 0x0 -> 0x0BADF00D).
